// File: rtl/systolic_array_db_pkg.sv
// Shared configuration for the double-buffered systolic array: default geometry,
// datapath widths and the weight-loader state encoding.
package systolic_array_db_pkg;

    localparam int sys_rows   = 4;
    localparam int sys_cols   = 4;
    localparam int A_BITWIDTH = 8;
    localparam int W_BITWIDTH = 8;
    localparam int P_BITWIDTH = 32;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/systolic_array_db_sa_pe.sv
// One weight-stationary processing element with a shadow/active weight pair,
// a registered activation pass-through (with valid) and a registered partial sum.
module sa_pe #(
    parameter int A_BW = 8,
    parameter int W_BW = 8,
    parameter int P_BW = 32
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   load_en_i,
    input  logic signed [W_BW-1:0] w_i,
    input  logic                   swap_i,
    input  logic signed [A_BW-1:0] a_i,
    input  logic                   a_valid_i,
    input  logic signed [P_BW-1:0] psum_i,
    output logic signed [A_BW-1:0] a_o,
    output logic                   a_valid_o,
    output logic signed [P_BW-1:0] psum_o
);

    logic signed [W_BW-1:0] w_shadow_q;
    logic signed [W_BW-1:0] w_active_q;
    logic signed [A_BW-1:0] a_q;
    logic                   a_valid_q;
    logic signed [P_BW-1:0] psum_q;
    logic signed [P_BW-1:0] psum_d;
    logic signed [P_BW-1:0] a_ext;
    logic signed [P_BW-1:0] w_ext;

    // Operands are sign-extended first so the product and sum wrap modulo 2^P_BW.
    assign a_ext  = P_BW'(a_i);
    assign w_ext  = P_BW'(w_active_q);
    assign psum_d = psum_i + a_ext * w_ext;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            w_shadow_q <= '0;
            w_active_q <= '0;
            a_q        <= '0;
            a_valid_q  <= 1'b0;
            psum_q     <= '0;
        end else begin
            if (load_en_i) begin
                w_shadow_q <= w_i;
            end
            if (swap_i) begin
                w_active_q <= w_shadow_q;
            end
            a_q       <= a_i;
            a_valid_q <= a_valid_i;
            psum_q    <= psum_d;
        end
    end

    assign a_o       = a_q;
    assign a_valid_o = a_valid_q;
    assign psum_o    = psum_q;

endmodule

// File: rtl/systolic_array_db.sv
// Weight-stationary systolic array with double-buffered weights, internal input skew
// and output deskew, a row-streaming weight loader and an in-flight (busy) counter.
module systolic_array_db
    import systolic_array_db_pkg::*;
#(
    parameter int ROWS = sys_rows,
    parameter int COLS = sys_cols,
    parameter int A_BW = A_BITWIDTH,
    parameter int W_BW = W_BITWIDTH,
    parameter int P_BW = P_BITWIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wl_valid,
    output logic                       wl_ready,
    input  logic [COLS-1:0][W_BW-1:0]  wl_data,
    input  logic [COLS-1:0][P_BW-1:0]  bias_in,
    input  logic                       swap,
    output logic                       swap_ack,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [ROWS-1:0][A_BW-1:0]  a_data,
    output logic                       out_valid,
    output logic [COLS-1:0][P_BW-1:0]  of_data,
    output logic                       busy
);

    localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BC_W = $clog2(ROWS + COLS + 1);

    loader_state_e             state_q, state_d;
    logic [RC_W-1:0]           row_cnt_q, row_cnt_d;
    logic                      act_valid_q;
    logic [COLS-1:0][P_BW-1:0] bias_q;
    logic [BC_W-1:0]           busy_q, busy_d;
    logic                      out_valid_q;
    logic                      swap_acc;
    logic                      wl_fire;
    logic                      a_fire;
    logic                      out_dec;

    // Grid wiring: activations move right along a row, partial sums move down a column.
    logic signed [A_BW-1:0] a_h  [ROWS][COLS+1];
    logic                   v_h  [ROWS][COLS+1];
    logic signed [P_BW-1:0] ps_v [ROWS+1][COLS];

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        wl_ready  = 1'b0;
        swap_acc  = 1'b0;
        case (state_q)
            LOAD: begin
                wl_ready = 1'b1;
                if (wl_valid) begin
                    if (row_cnt_q == RC_W'(ROWS - 1)) begin
                        state_d   = FULL;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                swap_acc = swap && (busy_q == '0);
                if (swap_acc) begin
                    state_d   = LOAD;
                    row_cnt_d = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign wl_fire  = wl_valid && wl_ready;
    assign swap_ack = swap_acc;
    assign a_ready  = act_valid_q && !swap_acc;
    assign a_fire   = a_valid && a_ready;
    // The bottom-right PE's valid is exactly the value the output valid register takes next.
    assign out_dec  = v_h[ROWS-1][COLS];

    always_comb begin
        busy_d = busy_q;
        if (a_fire && !out_dec) begin
            busy_d = busy_q + 1'b1;
        end else if (!a_fire && out_dec) begin
            busy_d = busy_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            row_cnt_q   <= '0;
            act_valid_q <= 1'b0;
            bias_q      <= '0;
            busy_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_dec;
            if (swap_acc) begin
                act_valid_q <= 1'b1;
                bias_q      <= bias_in;
            end
        end
    end

    assign busy      = (busy_q != '0);
    assign out_valid = out_valid_q;

    genvar gi, gj;

    // Row gi sees its element gi+1 cycles after acceptance, one cycle later than row gi-1.
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_skew
            logic [A_BW-1:0] sk_data_q [gi+1];
            logic            sk_vld_q  [gi+1];
            logic            unused_tail;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k <= gi; k++) begin
                        sk_data_q[k] <= '0;
                        sk_vld_q[k]  <= 1'b0;
                    end
                end else begin
                    sk_data_q[0] <= a_data[gi];
                    sk_vld_q[0]  <= a_fire;
                    for (int k = 1; k <= gi; k++) begin
                        sk_data_q[k] <= sk_data_q[k-1];
                        sk_vld_q[k]  <= sk_vld_q[k-1];
                    end
                end
            end

            assign a_h[gi][0]  = sk_data_q[gi];
            assign v_h[gi][0]  = sk_vld_q[gi];
            assign unused_tail = ^{a_h[gi][COLS], v_h[gi][COLS]};
        end
    endgenerate

    generate
        for (gj = 0; gj < COLS; gj++) begin : g_bias
            assign ps_v[0][gj] = bias_q[gj];
        end

        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                sa_pe #(
                    .A_BW (A_BW),
                    .W_BW (W_BW),
                    .P_BW (P_BW)
                ) u_pe (
                    .clk       (clk),
                    .rst_ni    (rst),
                    .load_en_i (wl_fire && (row_cnt_q == RC_W'(ROWS - 1 - gi))),
                    .w_i       (wl_data[gj]),
                    .swap_i    (swap_acc),
                    .a_i       (a_h[gi][gj]),
                    .a_valid_i (v_h[gi][gj]),
                    .psum_i    (ps_v[gi][gj]),
                    .a_o       (a_h[gi][gj+1]),
                    .a_valid_o (v_h[gi][gj+1]),
                    .psum_o    (ps_v[gi+1][gj])
                );
            end
        end
    endgenerate

    // Column gj leaves the grid gj cycles after column 0; COLS-gj stages realign them.
    generate
        for (gj = 0; gj < COLS; gj++) begin : g_deskew
            logic [P_BW-1:0] dk_q [COLS-gj];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < COLS - gj; k++) begin
                        dk_q[k] <= '0;
                    end
                end else begin
                    dk_q[0] <= ps_v[ROWS][gj];
                    for (int k = 1; k < COLS - gj; k++) begin
                        dk_q[k] <= dk_q[k-1];
                    end
                end
            end

            assign of_data[gj] = dk_q[COLS-1-gj];
        end
    endgenerate

endmodule
